// File: rtl/scoreboard_ctrl_if.sv
// Pipeline-side signal bundle for the register scoreboard: ID source/dest info,
// writeback commits, redirect/drain requests, and the resulting stall/flush controls.
interface scoreboard_ctrl_if;
   // Handshake: ID offers an instruction by raising id_valid_i. The instruction
   // is consumed on a rising edge only if hold_o and flush_o are both low that
   // cycle. While hold_o is high, ID must keep its fields stable. flush_o discards
   // the instruction regardless of hold_o.
   logic       id_valid_i;
   logic [4:0] id_rs1_addr_i;
   logic [4:0] id_rs2_addr_i;
   logic [4:0] id_rd_addr_i;
   logic       id_reg_wen_i;
   logic       wb_reg_wen_i;
   logic [4:0] wb_rd_addr_i;
   logic       jump_en_i;
   logic       drain_req_i;
   logic       hold_o;
   logic       bubble_o;
   logic       flush_o;
   logic       drain_ack_o;
   logic [5:0] pend_total_o;
   logic       err_o;

   modport master (
      output id_valid_i, id_rs1_addr_i, id_rs2_addr_i, id_rd_addr_i, id_reg_wen_i,
      output wb_reg_wen_i, wb_rd_addr_i, jump_en_i, drain_req_i,
      input  hold_o, bubble_o, flush_o, drain_ack_o, pend_total_o, err_o
   );

   modport slave (
      input  id_valid_i, id_rs1_addr_i, id_rs2_addr_i, id_rd_addr_i, id_reg_wen_i,
      input  wb_reg_wen_i, wb_rd_addr_i, jump_en_i, drain_req_i,
      output hold_o, bubble_o, flush_o, drain_ack_o, pend_total_o, err_o
   );
endinterface

// File: rtl/scoreboard_ctrl.sv
// Per-register pending-write scoreboard: stalls ID on RAW hazards or counter
// saturation, flushes on redirect, and drains all outstanding writes on request.
module scoreboard_ctrl #(
   parameter int CNT_W = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   scoreboard_ctrl_if.slave sb,
   output logic [1:0]       dbg_state_o
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DRAIN = 2'd1,
      ST_ACK   = 2'd2
   } state_e;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam int               SUM_W   = CNT_W + 5;

   logic [CNT_W-1:0] cnt_q [1:31];
   logic [CNT_W-1:0] cnt_d [1:31];
   logic [CNT_W-1:0] cur   [0:31];
   logic [CNT_W-1:0] eff   [0:31];
   logic [31:0]      wb_clr;
   logic [31:0]      inc;
   logic [SUM_W-1:0] sum;
   state_e           state_q, state_d;
   logic [5:0]       pend_q, pend_d;
   logic             err_q, err_d;
   logic             raw_stall, full_stall, issue, all_clear;

   // Effective counts already credit a same-cycle writeback (regfile forwards it).
   always_comb begin
      cur[0]    = '0;
      eff[0]    = '0;
      wb_clr    = '0;
      all_clear = 1'b1;
      for (int r = 1; r < 32; r++) begin
         cur[r]    = cnt_q[r];
         wb_clr[r] = sb.wb_reg_wen_i && (sb.wb_rd_addr_i == 5'(r)) && (cnt_q[r] != '0);
         eff[r]    = cnt_q[r] - CNT_W'(wb_clr[r]);
         if (eff[r] != '0) all_clear = 1'b0;
      end
   end

   always_comb begin
      raw_stall  = sb.id_valid_i &&
                   (((sb.id_rs1_addr_i != 5'd0) && (eff[sb.id_rs1_addr_i] != '0)) ||
                    ((sb.id_rs2_addr_i != 5'd0) && (eff[sb.id_rs2_addr_i] != '0)));
      full_stall = sb.id_valid_i && sb.id_reg_wen_i && (sb.id_rd_addr_i != 5'd0) &&
                   (eff[sb.id_rd_addr_i] == CNT_MAX);
      issue      = sb.id_valid_i && !raw_stall && !full_stall && !sb.jump_en_i &&
                   (state_q == ST_IDLE);
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (sb.drain_req_i) state_d = ST_DRAIN;
         ST_DRAIN: if (all_clear) state_d = ST_ACK;
         ST_ACK:   state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      inc = '0;
      sum = '0;
      if (issue && sb.id_reg_wen_i && (sb.id_rd_addr_i != 5'd0)) inc[sb.id_rd_addr_i] = 1'b1;
      for (int r = 1; r < 32; r++) begin
         cnt_d[r] = cnt_q[r] + CNT_W'(inc[r]) - CNT_W'(wb_clr[r]);
         sum      = sum + SUM_W'(cnt_d[r]);
      end
      pend_d = (sum > SUM_W'(63)) ? 6'd63 : 6'(sum);
      // x0 writebacks are architecturally discarded and never flagged.
      err_d  = err_q || (sb.wb_reg_wen_i && (sb.wb_rd_addr_i != 5'd0) &&
                         (cur[sb.wb_rd_addr_i] == '0));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int r = 1; r < 32; r++) cnt_q[r] <= '0;
         state_q <= ST_IDLE;
         pend_q  <= 6'd0;
         err_q   <= 1'b0;
      end else begin
         for (int r = 1; r < 32; r++) cnt_q[r] <= cnt_d[r];
         state_q <= state_d;
         pend_q  <= pend_d;
         err_q   <= err_d;
      end
   end

   assign sb.hold_o       = sb.id_valid_i && !sb.jump_en_i && !issue;
   assign sb.bubble_o     = sb.id_valid_i && !sb.jump_en_i && !issue;
   assign sb.flush_o      = sb.jump_en_i;
   assign sb.drain_ack_o  = (state_q == ST_ACK);
   assign sb.pend_total_o = pend_q;
   assign sb.err_o        = err_q;
   assign dbg_state_o     = state_q;

endmodule

// File: tb/tb_scoreboard_ctrl.sv
// Bench for scoreboard_ctrl: directed vector table, drain/error/reset sequences,
// saturation, and random traffic against a counting reference model.
module tb_scoreboard_ctrl;

   localparam int CNT_W = 2;
   localparam int MAXC  = (1 << CNT_W) - 1;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [1:0] dbg_state;

   always #5 clk = ~clk;

   scoreboard_ctrl_if sb_if ();

   scoreboard_ctrl #(.CNT_W(CNT_W)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .sb          (sb_if),
      .dbg_state_o (dbg_state)
   );

   typedef struct {
      logic       v;
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic [4:0] rd;
      logic       wen;
      logic       wbw;
      logic [4:0] wbrd;
      logic       jmp;
      logic       drq;
      logic       e_hold;
      logic       e_flush;
      logic [5:0] e_pend;
      logic       e_err;
      logic       e_ack;
   } vec_t;

   int          tests_run = 0;
   int          tests_failed = 0;
   int          pend [32];
   bit          m_err;
   int          m_phase;
   logic [5:0]  exp_q [$];
   logic        s_hold, s_bubble, s_flush, s_ack, s_err;
   logic [5:0]  s_pend;
   vec_t        tab [22];

   function automatic vec_t mk(input int v, rs1, rs2, rd, wen, wbw, wbrd, jmp, drq,
                               input int eh, ef, ep, ee, ea);
      vec_t t;
      t.v = 1'(v); t.rs1 = 5'(rs1); t.rs2 = 5'(rs2); t.rd = 5'(rd); t.wen = 1'(wen);
      t.wbw = 1'(wbw); t.wbrd = 5'(wbrd); t.jmp = 1'(jmp); t.drq = 1'(drq);
      t.e_hold = 1'(eh); t.e_flush = 1'(ef); t.e_pend = 6'(ep); t.e_err = 1'(ee);
      t.e_ack = 1'(ea);
      return t;
   endfunction

   function automatic vec_t iv(input int v, rs1, rs2, rd, wen, wbw, wbrd, jmp, drq);
      return mk(v, rs1, rs2, rd, wen, wbw, wbrd, jmp, drq, 0, 0, 0, 0, 0);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: outstanding writes per register, plus drain progress.
   function automatic int resolved(input vec_t in, input int r);
      int wb_hit;
      wb_hit = (in.wbw && int'(in.wbrd) == r && r != 0 && pend[r] > 0) ? 1 : 0;
      return pend[r] - wb_hit;
   endfunction

   function automatic bit can_issue(input vec_t in);
      bit hazard, full;
      hazard = (in.rs1 != 0 && resolved(in, int'(in.rs1)) > 0) ||
               (in.rs2 != 0 && resolved(in, int'(in.rs2)) > 0);
      full   = in.wen && in.rd != 0 && resolved(in, int'(in.rd)) >= MAXC;
      return in.v && !hazard && !full && !in.jmp && m_phase == 0;
   endfunction

   task automatic model_reset();
      for (int r = 0; r < 32; r++) pend[r] = 0;
      m_err   = 1'b0;
      m_phase = 0;
      exp_q.delete();
      exp_q.push_back(6'd0);
   endtask

   task automatic model_update(input vec_t in);
      bit iss;
      int total;
      iss = can_issue(in);
      if (in.wbw && in.wbrd != 0) begin
         if (pend[in.wbrd] > 0) pend[in.wbrd]--;
         else m_err = 1'b1;
      end
      if (iss && in.wen && in.rd != 0) pend[in.rd]++;
      total = 0;
      for (int r = 1; r < 32; r++) total += pend[r];
      if (m_phase == 0) begin
         if (in.drq) m_phase = 1;
      end else if (m_phase == 1) begin
         if (total == 0) m_phase = 2;
      end else begin
         m_phase = 0;
      end
      exp_q.push_back(6'((total > 63) ? 63 : total));
   endtask

   task automatic drive(input vec_t in);
      sb_if.id_valid_i    = in.v;
      sb_if.id_rs1_addr_i = in.rs1;
      sb_if.id_rs2_addr_i = in.rs2;
      sb_if.id_rd_addr_i  = in.rd;
      sb_if.id_reg_wen_i  = in.wen;
      sb_if.wb_reg_wen_i  = in.wbw;
      sb_if.wb_rd_addr_i  = in.wbrd;
      sb_if.jump_en_i     = in.jmp;
      sb_if.drain_req_i   = in.drq;
   endtask

   // One cycle: drive, sample at negedge, compare, then advance model at posedge.
   task automatic step(input vec_t in, input bit use_tab, input string tag);
      logic e_hold, e_flush, e_err, e_ack;
      logic [5:0] e_pend;
      drive(in);
      @(negedge clk);
      s_hold = sb_if.hold_o; s_bubble = sb_if.bubble_o; s_flush = sb_if.flush_o;
      s_ack = sb_if.drain_ack_o; s_err = sb_if.err_o; s_pend = sb_if.pend_total_o;
      e_flush = in.jmp;
      e_hold  = in.v && !in.jmp && !can_issue(in);
      e_ack   = (m_phase == 2);
      e_err   = m_err;
      if (exp_q.size() == 0) begin
         e_pend = 6'h3f;
         chk({tag, "_queue_empty"}, 1, 0);
      end else begin
         e_pend = exp_q.pop_front();
      end
      if (use_tab) begin
         e_hold = in.e_hold; e_flush = in.e_flush; e_pend = in.e_pend;
         e_err = in.e_err; e_ack = in.e_ack;
      end
      chk({tag, "_hold"}, s_hold, e_hold);
      chk({tag, "_bubble"}, s_bubble, e_hold);
      chk({tag, "_flush"}, s_flush, e_flush);
      chk({tag, "_ack"}, s_ack, e_ack);
      chk({tag, "_err"}, s_err, e_err);
      chk({tag, "_pend"}, s_pend, e_pend);
      chk({tag, "_model_sync"}, {26'd0, e_pend}, {26'd0, s_pend});
      @(posedge clk);
      model_update(in);
      #1;
   endtask

   task automatic release_reset();
      drive(iv(0, 0, 0, 0, 0, 0, 0, 0, 0));
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      model_reset();
   endtask

   function automatic vec_t rand_vec();
      vec_t t;
      int r;
      t = iv(0, 0, 0, 0, 0, 0, 0, 0, 0);
      t.v   = ($urandom_range(0, 3) != 0);
      t.rs1 = 5'($urandom_range(0, 7));
      t.rs2 = 5'($urandom_range(0, 7));
      t.rd  = 5'($urandom_range(0, 7));
      t.wen = ($urandom_range(0, 3) != 0);
      r = $urandom_range(1, 7);
      if (pend[r] > 0 && $urandom_range(0, 1) == 1) begin
         t.wbw = 1'b1; t.wbrd = 5'(r);
      end else begin
         t.wbw = 1'b0; t.wbrd = 5'($urandom_range(0, 31));
      end
      t.jmp = ($urandom_range(0, 9) == 0);
      t.drq = ($urandom_range(0, 19) == 0);
      return t;
   endfunction

   initial begin
      //            v rs1 rs2 rd wen wbw wbrd jmp drq | hold flush pend err ack
      tab[0]  = mk(1, 0, 0, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      tab[1]  = mk(1, 5, 0, 6, 1, 0, 0, 0, 0, 1, 0, 1, 0, 0);
      tab[2]  = mk(1, 0, 5, 6, 1, 0, 0, 0, 0, 1, 0, 1, 0, 0);
      tab[3]  = mk(1, 5, 0, 6, 1, 1, 5, 0, 0, 0, 0, 1, 0, 0);
      tab[4]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
      tab[5]  = mk(0, 0, 0, 0, 0, 1, 6, 0, 0, 0, 0, 1, 0, 0);
      tab[6]  = mk(1, 0, 0, 7, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      tab[7]  = mk(1, 0, 0, 7, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
      tab[8]  = mk(1, 0, 0, 7, 1, 0, 0, 0, 0, 0, 0, 2, 0, 0);
      tab[9]  = mk(1, 0, 0, 7, 1, 0, 0, 0, 0, 1, 0, 3, 0, 0);
      tab[10] = mk(1, 0, 0, 7, 1, 0, 0, 1, 0, 0, 1, 3, 0, 0);
      tab[11] = mk(1, 7, 0, 8, 1, 0, 0, 1, 0, 0, 1, 3, 0, 0);
      tab[12] = mk(1, 7, 0, 8, 1, 0, 0, 0, 0, 1, 0, 3, 0, 0);
      tab[13] = mk(1, 0, 0, 7, 1, 1, 7, 0, 0, 0, 0, 3, 0, 0);
      tab[14] = mk(1, 0, 0, 7, 1, 0, 0, 0, 0, 1, 0, 3, 0, 0);
      tab[15] = mk(0, 0, 0, 0, 0, 1, 7, 0, 0, 0, 0, 3, 0, 0);
      tab[16] = mk(0, 0, 0, 0, 0, 1, 7, 0, 0, 0, 0, 2, 0, 0);
      tab[17] = mk(0, 0, 0, 0, 0, 1, 7, 0, 0, 0, 0, 1, 0, 0);
      tab[18] = mk(1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      tab[19] = mk(1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      tab[20] = mk(1, 0, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      tab[21] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

      // Clock/reset
      rst_n = 1'b0;
      drive(iv(0, 0, 0, 0, 0, 0, 0, 0, 0));
      repeat (2) @(negedge clk);
      chk("reset_pend", sb_if.pend_total_o, 0);
      chk("reset_err", sb_if.err_o, 0);
      chk("reset_ack", sb_if.drain_ack_o, 0);
      chk("reset_state_idle", dbg_state, 0);
      release_reset();

      // Directed table: RAW stall, full stall, jump override, x0 handling
      for (int i = 0; i < 22; i++) step(tab[i], 1'b1, $sformatf("tab%0d", i));

      // Drain with nothing pending: ack two cycles after the request
      step(iv(0, 0, 0, 0, 0, 0, 0, 0, 1), 1'b0, "dr0_req");
      chk("dr0_ack_req_cycle", s_ack, 0);
      step(iv(0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0, "dr0_c1");
      chk("dr0_ack_c1", s_ack, 0);
      step(iv(0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0, "dr0_c2");
      chk("dr0_ack_c2", s_ack, 1);
      step(iv(0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0, "dr0_c3");
      chk("dr0_ack_c3", s_ack, 0);

      // Drain with two pending writes
      step(iv(1, 0, 0, 10, 1, 0, 0, 0, 0), 1'b0, "dr2_i10");
      step(iv(1, 0, 0, 11, 1, 0, 0, 0, 0), 1'b0, "dr2_i11");
      step(iv(0, 0, 0, 0, 0, 0, 0, 0, 1), 1'b0, "dr2_req");
      chk("dr2_pend_at_req", s_pend, 2);
      step(iv(1, 0, 0, 12, 1, 0, 0, 0, 1), 1'b0, "dr2_d1");
      chk("dr2_hold_in_drain", s_hold, 1);
      step(iv(1, 0, 0, 12, 1, 1, 10, 0, 0), 1'b0, "dr2_wb10");
      chk("dr2_ack_wb10", s_ack, 0);
      step(iv(1, 0, 0, 12, 1, 1, 11, 0, 0), 1'b0, "dr2_wb11");
      chk("dr2_ack_last_wb", s_ack, 0);
      step(iv(1, 0, 0, 12, 1, 0, 0, 0, 1), 1'b0, "dr2_ack");
      chk("dr2_ack_pulse", s_ack, 1);
      chk("dr2_hold_in_ack", s_hold, 1);
      chk("dr2_pend_empty", s_pend, 0);
      step(iv(1, 0, 0, 12, 1, 0, 0, 0, 0), 1'b0, "dr2_idle");
      chk("dr2_ack_gone", s_ack, 0);
      chk("dr2_issue_idle", s_hold, 0);
      step(iv(0, 0, 0, 0, 0, 1, 12, 0, 0), 1'b0, "dr2_wb12");

      // Writeback with no pending write: sticky error
      step(iv(0, 0, 0, 0, 0, 1, 9, 0, 0), 1'b0, "err_wb9");
      chk("err_before_edge", s_err, 0);
      step(iv(1, 0, 0, 9, 1, 0, 0, 0, 0), 1'b0, "err_i9");
      chk("err_set", s_err, 1);
      step(iv(0, 0, 0, 0, 0, 1, 9, 0, 0), 1'b0, "err_goodwb");
      step(iv(1, 0, 0, 9, 1, 0, 0, 0, 1), 1'b0, "err_dreq");
      chk("err_sticky", s_err, 1);
      step(iv(0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0, "mid_drain");
      chk("mid_drain_pend", s_pend, 1);

      // Asynchronous reset while draining
      rst_n = 1'b0;
      #2;
      chk("arst_pend", sb_if.pend_total_o, 0);
      chk("arst_err", sb_if.err_o, 0);
      chk("arst_ack", sb_if.drain_ack_o, 0);
      chk("arst_state_idle", dbg_state, 0);
      release_reset();
      for (int i = 0; i < 3; i++) begin
         step(iv(0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0, "post_rst");
         chk("post_rst_no_ack", s_ack, 0);
      end
      step(iv(1, 9, 0, 2, 1, 0, 0, 0, 0), 1'b0, "post_rst_issue");
      chk("post_rst_issue_hold", s_hold, 0);

      // pend_total saturation: 66 writes outstanding
      rst_n = 1'b0;
      #2;
      release_reset();
      for (int r = 1; r <= 22; r++)
         for (int k = 0; k < 3; k++) step(iv(1, 0, 0, r, 1, 0, 0, 0, 0), 1'b0, "sat");
      step(iv(1, 0, 0, 1, 1, 0, 0, 0, 0), 1'b0, "sat_full");
      chk("sat_pend_63", s_pend, 63);
      chk("sat_full_hold", s_hold, 1);

      // Random traffic against the model
      rst_n = 1'b0;
      #2;
      release_reset();
      for (int i = 0; i < 1500; i++) step(rand_vec(), 1'b0, "rnd");

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
